hazard_ctrl_p: RTL

- Parametrised successor to the current 5-stage pipeline hazard unit.
- Generates stall, flush and forward controls for the F/D/E/M/W pipeline.
- Adds three capabilities the existing unit lacks: a multi-cycle execute unit (MDU), variable-latency data memory with a ready handshake and watchdog, and a no-forwarding mode.
- Also holds stall/flush performance counters readable by the bench.

---
 rtl/hazard_ctrl_p.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_p.sv
// Hazard unit for the F/D/E/M/W pipeline: stall, flush and operand-forward
// control, a multi-cycle execute (MDU) sequencer, memory-wait watchdog and perf counters.
module hazard_ctrl_p #(
    parameter int ADDR_W      = 5,
    parameter int MDU_LAT     = 4,
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_d,
    input  logic [ADDR_W-1:0] rs2_d,
    input  logic [ADDR_W-1:0] rs1_e,
    input  logic [ADDR_W-1:0] rs2_e,
    input  logic [ADDR_W-1:0] rd_e,
    input  logic              regwrite_e,
    input  logic              load_e,
    input  logic              mdu_e,
    input  logic              pcsrc_e,
    input  logic [ADDR_W-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic              mem_req_m,
    input  logic              mem_ready_m,
    input  logic [ADDR_W-1:0] rd_w,
    input  logic              regwrite_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              mdu_busy,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int MDU_CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MDU_CW-1:0] MduLoad = MDU_CW'(MDU_LAT - 1);
    localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MEM_TIMEOUT);
    localparam bit NoFwd = (FWD_EN == 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

    mdu_state_e        state_q, state_d;
    logic [MDU_CW-1:0] mduCnt_q, mduCnt_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              timeout_q;
    logic [CNT_W-1:0]  stallCnt_q, flushCnt_q;

    logic memWait, mduTrigger, matchE, matchM, rawD, pcsrcWin;

    assign memWait    = mem_req_m && !mem_ready_m;
    assign mduTrigger = (state_q == IDLE) && mdu_e && !memWait;
    assign matchE     = (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign matchM     = (rd_m != '0) && ((rd_m == rs1_d) || (rd_m == rs2_d));
    // Without forwarding, any in-flight writer in E or M must drain first; W is safe
    // because the register file writes on the falling edge.
    assign rawD = (load_e && regwrite_e && matchE) ||
                  (NoFwd && ((regwrite_e && matchE) || (regwrite_m && matchM)));

    function automatic logic [1:0] fwdSel(input logic [ADDR_W-1:0] rs,
                                          input logic [ADDR_W-1:0] rdM, input logic wrM,
                                          input logic [ADDR_W-1:0] rdW, input logic wrW);
        if (wrM && (rdM != '0) && (rdM == rs)) return 2'b10;
        if (wrW && (rdW != '0) && (rdW == rs)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        forward_ae = 2'b00;
        forward_be = 2'b00;
        if (rst && !NoFwd) begin
            forward_ae = fwdSel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
            forward_be = fwdSel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
        end
    end

    // MDU sequencer: everything holds while memory is stalling the pipe.
    always_comb begin
        state_d  = state_q;
        mduCnt_d = mduCnt_q;
        if (!memWait) begin
            case (state_q)
                IDLE: begin
                    if (mdu_e) begin
                        if (MDU_LAT == 1) begin
                            state_d = DONE;
                        end else begin
                            state_d  = BUSY;
                            mduCnt_d = MduLoad;
                        end
                    end
                end
                BUSY: begin
                    if (mduCnt_q == '0) state_d = DONE;
                    else                mduCnt_d = mduCnt_q - MDU_CW'(1);
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        flush_w  = 1'b0;
        pcsrcWin = 1'b0;
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else if (memWait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (mduTrigger || (state_q == BUSY)) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (pcsrc_e) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            pcsrcWin = 1'b1;
        end else if (rawD) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        waitCnt_d = '0;
        if (memWait) waitCnt_d = (waitCnt_q == WaitMax) ? waitCnt_q : waitCnt_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mduCnt_q   <= '0;
            waitCnt_q  <= '0;
            timeout_q  <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mduCnt_q  <= mduCnt_d;
            waitCnt_q <= waitCnt_d;
            if (waitCnt_d == WaitMax) timeout_q <= 1'b1;
            if (stall_f && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + CNT_W'(1);
            if (pcsrcWin && (flushCnt_q != '1)) flushCnt_q <= flushCnt_q + CNT_W'(1);
        end
    end

    assign mdu_busy    = rst && (state_q != IDLE);
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stallCnt_q;
    assign flush_cnt   = flushCnt_q;

endmodule
